cmd_dispatcher: RTL

CMD_DISPATCHER -- requirements
Module: cmd_dispatcher

---
 rtl/cmd_dispatch_pkg.sv | 13 +
 rtl/cmd_fifo.sv | 51 +++++
 rtl/cmd_dispatcher.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cmd_dispatch_pkg.sv
// Command dispatcher shared types.
// FSM encoding, command and timeout widths.
package cmd_dispatch_pkg;
  localparam int CMD_W = 8;
  localparam int TMO_W = 28;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    POP       = 2'd1,
    REQ       = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO, single clock.
// Registered count; full/empty come from it.
module cmd_fifo
  import cmd_dispatch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] din,
  output logic [CMD_W-1:0] dout,
  output logic [4:0]       count,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] DEP = 5'(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == DEP);
  assign empty = (count == 5'd0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  // Pointers wrap naturally; count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {4'd0, wr_en}
                     - {4'd0, rd_en};
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/cmd_dispatcher.sv
// Command dispatcher: FIFO plus str/ack
// handshake FSM with sticky error flags.
module cmd_dispatcher
  import cmd_dispatch_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int MAX_CMD     = 15,
  parameter int ACK_TIMEOUT = 250_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd_in,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             err_clr,
  output logic [CMD_W-1:0] command,
  output logic             str,
  input  logic             ready_command,
  output logic [4:0]       count,
  output logic             busy,
  output logic             overflow_err,
  output logic             bad_cmd_err,
  output logic             timeout_err
);
  localparam logic [CMD_W-1:0] MAX_C =
    CMD_W'(MAX_CMD);
  localparam logic [TMO_W-1:0] TMO =
    TMO_W'(ACK_TIMEOUT);

  state_t           state;
  state_t           state_n;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_n;
  logic             pop;
  logic             tmo_evt;
  logic             full;
  logic             empty;
  logic             legal;
  logic             push;
  logic             bad_evt;
  logic             ovf_evt;
  logic [CMD_W-1:0] head;

  assign legal     = (cmd_in <= MAX_C);
  assign push      = cmd_valid && legal;
  assign cmd_ready = !full;
  assign bad_evt   = cmd_valid && !legal;
  assign ovf_evt   = cmd_valid && full;
  assign str       = (state == REQ);
  assign busy      = (state != IDLE) ||
                     (count != 5'd0);

  cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (cmd_in),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Next state, ack timer and pop strobe.
  always_comb begin
    state_n = state;
    tmo_n   = '0;
    pop     = 1'b0;
    tmo_evt = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) state_n = POP;
      end
      POP: begin
        pop     = 1'b1;
        state_n = REQ;
      end
      REQ: begin
        if (!ready_command) begin
          state_n = WAIT_DONE;
        end else begin
          tmo_n = tmo_cnt + TMO_W'(1);
          if (tmo_n == TMO) begin
            tmo_evt = 1'b1;
            tmo_n   = '0;
            state_n = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (ready_command) state_n = IDLE;
      end
    endcase
  end

  // State, timer and presented command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      command <= '0;
    end else begin
      state   <= state_n;
      tmo_cnt <= tmo_n;
      if (pop) command <= head;
    end
  end

  // Sticky flags; a new event beats err_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_err <= 1'b0;
      bad_cmd_err  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      overflow_err <= ovf_evt |
        (overflow_err & ~err_clr);
      bad_cmd_err  <= bad_evt |
        (bad_cmd_err & ~err_clr);
      timeout_err  <= tmo_evt |
        (timeout_err & ~err_clr);
    end
  end
endmodule
